iob_ram_t2p_asym_sc: RTL and testbench
======================================

Name: iob_ram_t2p_asym_sc

Overview:
Single-clock two-port RAM with independent write and read ports of different data widths (asymmetric). Narrow-word addresses are finer-grained views of the same storage as wide words, with little-endian lane packing. It is used as a width-converting buffer between a write-side producer and a read-side consumer that share one clock domain.

Parameters:
W_DATA_W, 32, write port data width; power of 2, at least 1.
R_DATA_W, 8, read port data width; power of 2, at least 1.
ADDR_W, 10, address width of the narrower port, which is the maximum address width.
Derived localparams, not overridable:
- MAXDATA_W = max(W_DATA_W, R_DATA_W); MINDATA_W = min(W_DATA_W, R_DATA_W).
- RATIO = MAXDATA_W/MINDATA_W, a power of 2.
- MINADDR_W = ADDR_W - log2(RATIO); requires ADDR_W > log2(RATIO).
- W_ADDR_W = ADDR_W if W_DATA_W == MINDATA_W, else MINADDR_W.
- R_ADDR_W = ADDR_W if R_DATA_W == MINDATA_W, else MINADDR_W.

Ports:
clk  input  1  single clock; all state updates on its rising edge.
rst_n  input  1  asynchronous active-low reset.
w_en  input  1  write enable.
w_addr  input  W_ADDR_W  write address in W_DATA_W-sized words.
w_data  input  W_DATA_W  write data.
r_en  input  1  read enable.
r_addr  input  R_ADDR_W  read address in R_DATA_W-sized words.
r_data  output  R_DATA_W  registered read data.

Behaviour:
- Storage is 2**ADDR_W * MINDATA_W bits total, modelled as a linear bit image.
- Narrow word n occupies image bits [n*MINDATA_W +: MINDATA_W].
- Wide word k = narrow words k*RATIO .. k*RATIO+RATIO-1, lowest address in the LSBs.
- Write: at a posedge with w_en=1, w_data is stored at image bits [w_addr*W_DATA_W +: W_DATA_W].
  - If W_DATA_W is the wide side, all RATIO lanes of the word are written in the same cycle.
  - w_en=0 leaves storage unchanged.
- Read: at a posedge with r_en=1, r_data is loaded with image bits [r_addr*R_DATA_W +: R_DATA_W].
  - Latency is 1 cycle: the value is visible after the edge that samples r_addr.
  - If R_DATA_W is the wide side, RATIO consecutive narrow words are concatenated, lower address in the LSBs.
- r_en=0: r_data holds its previous value.
- Same-cycle read and write to overlapping bits: read-before-write. r_data returns the old contents; the new data is visible from the next read.
- Writes and reads are fully independent otherwise; both may be active every cycle.
- Reset:
  - rst_n=0 asynchronously clears r_data to 0 and holds it there while asserted.
  - Memory contents are NOT reset.
  - Writes and reads are ignored while rst_n=0.
  - Reset asserted mid-stream aborts the pending read; previously written data survives.
- Unwritten locations read as undefined (X in simulation).
- Equal widths (RATIO=1): plain dual-port RAM with W_ADDR_W = R_ADDR_W = ADDR_W.
- Implementation: one RAM bank per MINDATA_W lane, RATIO banks each 2**MINADDR_W deep.
  - The narrow-side address splits into bank select (low log2(RATIO) bits) and bank row (high bits).
  - Generate branches cover W>R, W<R and W=R.

Test Plan:
1. Defaults (32→8, W_ADDR_W=8, R_ADDR_W=10), write direction: write w_addr=i, w_data=i+10 for i=0..255. Then read r_addr=0..1023 with r_en=1.
   - Expect r_addr 0→0x0a, 1→0x00, 2→0x00, 3→0x00, 4→0x0b, 1020→0x09 (word 255 = 0x109, byte 0), 1021→0x01.
2. W_DATA_W=8, R_DATA_W=32 (W_ADDR_W=10, R_ADDR_W=8): write byte i = (i+10)&0xFF for i=0..1023.
   - Read r_addr=0 → 0x0d0c0b0a; r_addr=1 → 0x11100f0e.
3. W_DATA_W=R_DATA_W=16, ADDR_W=10: write addr i with i+10, then read back.
   - Expect r_addr 5 → 0x000f, with data one cycle after r_en.
4. Read-during-write, defaults: byte 4 = 0x0b; same cycle, write w_addr=1 with 0xdeadbeef and read r_addr=4.
   - Expect r_data=0x0b; the next read of r_addr=4 → 0xef, r_addr=7 → 0xde.
5. r_en deassert: read r_addr=0 (0x0a), then set r_en=0 and r_addr=4 for 3 cycles.
   - Expect r_data stays 0x0a.
6. Reset: pulse rst_n=0 asynchronously between edges after a read.
   - Expect r_data=0 immediately. After release, read r_addr=0 → 0x0a (contents retained).

Source files
------------

// File: rtl/iob_ram_t2p_asym_sc_if.sv
// ----------------------------------------------------------------------------
// iob_ram_t2p_asym_sc_if
// Bus bundle for the asymmetric two-port RAM. Carries the write port
// (w_en, w_addr, w_data) and the read port (r_en, r_addr, r_data).
// Address widths follow the port data widths: the narrow side addresses
// every MINDATA_W word (ADDR_W bits), the wide side addresses whole wide words.
//   master : drives enables, addresses and write data; receives r_data
//   slave  : the RAM side
// ----------------------------------------------------------------------------
interface iob_ram_t2p_asym_sc_if #(
    parameter int W_DATA_W = 32,
    parameter int R_DATA_W = 8,
    parameter int ADDR_W   = 10
);
    localparam int MAXDATA_W = (W_DATA_W > R_DATA_W) ? W_DATA_W : R_DATA_W;
    localparam int MINDATA_W = (W_DATA_W > R_DATA_W) ? R_DATA_W : W_DATA_W;
    localparam int RATIO     = MAXDATA_W / MINDATA_W;
    localparam int MINADDR_W = ADDR_W - $clog2(RATIO);
    localparam int W_ADDR_W  = (W_DATA_W == MINDATA_W) ? ADDR_W : MINADDR_W;
    localparam int R_ADDR_W  = (R_DATA_W == MINDATA_W) ? ADDR_W : MINADDR_W;

    logic                w_en;
    logic [W_ADDR_W-1:0] w_addr;
    logic [W_DATA_W-1:0] w_data;
    logic                r_en;
    logic [R_ADDR_W-1:0] r_addr;
    logic [R_DATA_W-1:0] r_data;

    modport master (
        output w_en, w_addr, w_data, r_en, r_addr,
        input  r_data
    );

    modport slave (
        input  w_en, w_addr, w_data, r_en, r_addr,
        output r_data
    );
endinterface

// File: rtl/iob_ram_t2p_asym_sc.sv
// ----------------------------------------------------------------------------
// iob_ram_t2p_asym_sc
// Single-clock two-port RAM with a write port of W_DATA_W bits and a read
// port of R_DATA_W bits over one shared storage image. Narrow words are
// little-endian lanes of wide words (lowest narrow address in the LSBs).
// Storage is RATIO banks of MINDATA_W bits, each 2**MINADDR_W deep; a
// narrow-side address splits into bank select (low bits) and bank row.
// Ports:
//   clk   : clock, all updates on rising edge
//   rst_n : asynchronous active-low reset (clears r_data only)
//   bus   : slave side of iob_ram_t2p_asym_sc_if (write/read ports)
// Read data is registered (1-cycle latency), holds when r_en=0, and returns
// old contents on a same-cycle read/write to overlapping bits.
// ----------------------------------------------------------------------------
module iob_ram_t2p_asym_sc #(
    parameter int W_DATA_W = 32,
    parameter int R_DATA_W = 8,
    parameter int ADDR_W   = 10
) (
    input logic                  clk,
    input logic                  rst_n,
    iob_ram_t2p_asym_sc_if.slave bus
);
    localparam int MAXDATA_W = (W_DATA_W > R_DATA_W) ? W_DATA_W : R_DATA_W;
    localparam int MINDATA_W = (W_DATA_W > R_DATA_W) ? R_DATA_W : W_DATA_W;
    localparam int RATIO     = MAXDATA_W / MINDATA_W;
    localparam int SEL_W     = $clog2(RATIO);
    localparam int MINADDR_W = ADDR_W - SEL_W;
    localparam int W_ADDR_W  = (W_DATA_W == MINDATA_W) ? ADDR_W : MINADDR_W;
    localparam int R_ADDR_W  = (R_DATA_W == MINDATA_W) ? ADDR_W : MINADDR_W;
    localparam int DEPTH     = 2 ** MINADDR_W;

    logic                w_en;
    logic [W_ADDR_W-1:0] w_addr;
    logic [W_DATA_W-1:0] w_data;
    logic                r_en;
    logic [R_ADDR_W-1:0] r_addr;
    logic [R_DATA_W-1:0] rd_word;
    logic [R_DATA_W-1:0] r_data_q;

    // Writes are suppressed while reset is asserted; memory itself has no reset.
    assign w_en   = bus.w_en & rst_n;
    assign w_addr = bus.w_addr;
    assign w_data = bus.w_data;
    assign r_en   = bus.r_en;
    assign r_addr = bus.r_addr;

    if (W_DATA_W > R_DATA_W) begin : g_wide_write
        logic [MINDATA_W-1:0] mem [RATIO][DEPTH];
        logic [SEL_W-1:0]     r_sel;
        logic [MINADDR_W-1:0] r_row;

        assign r_sel = r_addr[SEL_W-1:0];
        assign r_row = r_addr[R_ADDR_W-1:SEL_W];

        // NOTE: storage arrays are deliberately left out of reset so they map
        // onto RAM macros; only the output register is reset.
        always_ff @(posedge clk) begin
            if (w_en) begin
                for (int j = 0; j < RATIO; j++) begin
                    mem[j][w_addr] <= w_data[j*MINDATA_W +: MINDATA_W];
                end
            end
        end

        assign rd_word = mem[r_sel][r_row];
    end else if (W_DATA_W < R_DATA_W) begin : g_wide_read
        logic [MINDATA_W-1:0] mem [RATIO][DEPTH];
        logic [SEL_W-1:0]     w_sel;
        logic [MINADDR_W-1:0] w_row;

        assign w_sel = w_addr[SEL_W-1:0];
        assign w_row = w_addr[W_ADDR_W-1:SEL_W];

        always_ff @(posedge clk) begin
            if (w_en) begin
                mem[w_sel][w_row] <= w_data;
            end
        end

        // NOTE: the default assignment first keeps this block free of latches.
        always_comb begin
            rd_word = '0;
            for (int j = 0; j < RATIO; j++) begin
                rd_word[j*MINDATA_W +: MINDATA_W] = mem[j][r_addr];
            end
        end
    end else begin : g_equal
        logic [MINDATA_W-1:0] mem [DEPTH];

        always_ff @(posedge clk) begin
            if (w_en) begin
                mem[w_addr] <= w_data;
            end
        end

        assign rd_word = mem[r_addr];
    end

    // NOTE: non-blocking updates make a same-edge read see the pre-write
    // contents, which gives read-before-write without extra logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_q <= '0;
        end else if (r_en) begin
            r_data_q <= rd_word;
        end
    end

    assign bus.r_data = r_data_q;
endmodule

// File: tb/tb_iob_ram_t2p_asym_sc.sv
// ----------------------------------------------------------------------------
// tb_iob_ram_t2p_asym_sc
// Directed bench for three configurations sharing one clock and reset:
//   u_dut_a : 32-bit write, 8-bit read (defaults)
//   u_dut_b : 8-bit write, 32-bit read
//   u_dut_c : 16-bit write, 16-bit read
// ----------------------------------------------------------------------------
module tb_iob_ram_t2p_asym_sc;
    logic clk = 1'b0;
    logic rst_n = 1'b1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    iob_ram_t2p_asym_sc_if #(.W_DATA_W(32), .R_DATA_W(8),  .ADDR_W(10)) bus_a ();
    iob_ram_t2p_asym_sc_if #(.W_DATA_W(8),  .R_DATA_W(32), .ADDR_W(10)) bus_b ();
    iob_ram_t2p_asym_sc_if #(.W_DATA_W(16), .R_DATA_W(16), .ADDR_W(10)) bus_c ();

    iob_ram_t2p_asym_sc #(.W_DATA_W(32), .R_DATA_W(8),  .ADDR_W(10)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a)
    );
    iob_ram_t2p_asym_sc #(.W_DATA_W(8),  .R_DATA_W(32), .ADDR_W(10)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b)
    );
    iob_ram_t2p_asym_sc #(.W_DATA_W(16), .R_DATA_W(16), .ADDR_W(10)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .bus(bus_c)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_a(input int addr);
        bus_a.r_en   = 1'b1;
        bus_a.r_addr = 10'(addr);
        tick();
    endtask

    int dir_addr [7] = '{0, 1, 2, 3, 4, 1020, 1021};
    int dir_exp  [7] = '{'h0a, 'h00, 'h00, 'h00, 'h0b, 'h09, 'h01};

    initial begin
        bus_a.w_en = 1'b0; bus_a.w_addr = '0; bus_a.w_data = '0;
        bus_a.r_en = 1'b0; bus_a.r_addr = '0;
        bus_b.w_en = 1'b0; bus_b.w_addr = '0; bus_b.w_data = '0;
        bus_b.r_en = 1'b0; bus_b.r_addr = '0;
        bus_c.w_en = 1'b0; bus_c.w_addr = '0; bus_c.w_data = '0;
        bus_c.r_en = 1'b0; bus_c.r_addr = '0;

        // Reset: r_data clears asynchronously, no clock edge needed.
        #1 rst_n = 1'b0;
        #1;
        check("reset_a", 32'(bus_a.r_data), 32'h0);
        check("reset_b", bus_b.r_data, 32'h0);
        check("reset_c", 32'(bus_c.r_data), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // 1. 32-bit writes, 8-bit reads.
        for (int i = 0; i < 256; i++) begin
            bus_a.w_en   = 1'b1;
            bus_a.w_addr = 8'(i);
            bus_a.w_data = 32'(i + 10);
            tick();
        end
        bus_a.w_en = 1'b0;
        for (int k = 0; k < 7; k++) begin
            read_a(dir_addr[k]);
            check($sformatf("wn_dir_%0d", dir_addr[k]), 32'(bus_a.r_data), 32'(dir_exp[k]));
        end
        for (int i = 0; i < 1024; i++) begin
            read_a(i);
            check($sformatf("wn_sweep_%0d", i), 32'(bus_a.r_data),
                  32'((((i >> 2) + 10) >> (8 * (i % 4))) & 'hff));
        end

        // 2. 8-bit writes, 32-bit reads.
        for (int i = 0; i < 1024; i++) begin
            bus_b.w_en   = 1'b1;
            bus_b.w_addr = 10'(i);
            bus_b.w_data = 8'((i + 10) & 'hff);
            tick();
        end
        bus_b.w_en = 1'b0;
        bus_b.r_en = 1'b1;
        bus_b.r_addr = 8'd0;   tick(); check("nw_r0",   bus_b.r_data, 32'h0d0c0b0a);
        bus_b.r_addr = 8'd1;   tick(); check("nw_r1",   bus_b.r_data, 32'h11100f0e);
        bus_b.r_addr = 8'd255; tick(); check("nw_r255", bus_b.r_data, 32'h09080706);
        bus_b.r_en = 1'b0;

        // 3. Equal 16-bit widths, including the one-cycle read latency.
        for (int i = 0; i < 1024; i++) begin
            bus_c.w_en   = 1'b1;
            bus_c.w_addr = 10'(i);
            bus_c.w_data = 16'(i + 10);
            tick();
        end
        bus_c.w_en = 1'b0;
        bus_c.r_en = 1'b1;
        bus_c.r_addr = 10'd0; tick(); check("eq_r0", 32'(bus_c.r_data), 32'h000a);
        bus_c.r_addr = 10'd5;
        #2; check("eq_latency_before_edge", 32'(bus_c.r_data), 32'h000a);
        tick(); check("eq_r5", 32'(bus_c.r_data), 32'h000f);
        bus_c.r_addr = 10'd1023; tick(); check("eq_r1023", 32'(bus_c.r_data), 32'h0409);
        bus_c.r_en = 1'b0;

        // 4. Read-during-write to overlapping bits returns old data.
        bus_a.w_en   = 1'b1;
        bus_a.w_addr = 8'd1;
        bus_a.w_data = 32'hdeadbeef;
        read_a(4);
        bus_a.w_en = 1'b0;
        check("rdw_old", 32'(bus_a.r_data), 32'h0b);
        read_a(4); check("rdw_new_b0", 32'(bus_a.r_data), 32'hef);
        read_a(5); check("rdw_new_b1", 32'(bus_a.r_data), 32'hbe);
        read_a(6); check("rdw_new_b2", 32'(bus_a.r_data), 32'had);
        read_a(7); check("rdw_new_b3", 32'(bus_a.r_data), 32'hde);

        // 5. r_en low holds r_data even as r_addr changes.
        read_a(0); check("hold_start", 32'(bus_a.r_data), 32'h0a);
        bus_a.r_en   = 1'b0;
        bus_a.r_addr = 10'd4;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("hold_%0d", i), 32'(bus_a.r_data), 32'h0a);
        end

        // 6. Async reset mid-cycle; writes ignored during reset, contents kept.
        read_a(0); check("rst_pre", 32'(bus_a.r_data), 32'h0a);
        #2 rst_n = 1'b0;
        #1; check("rst_async", 32'(bus_a.r_data), 32'h0);
        bus_a.w_en   = 1'b1;
        bus_a.w_addr = 8'd0;
        bus_a.w_data = 32'hffffffff;
        bus_a.r_en   = 1'b1;
        bus_a.r_addr = 10'd0;
        tick(); check("rst_held", 32'(bus_a.r_data), 32'h0);
        tick();
        bus_a.w_en = 1'b0;
        bus_a.r_en = 1'b0;
        rst_n = 1'b1;
        tick(); check("rst_released_idle", 32'(bus_a.r_data), 32'h0);
        read_a(0); check("rst_retained", 32'(bus_a.r_data), 32'h0a);
        read_a(1); check("rst_retained_b1", 32'(bus_a.r_data), 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
